// File: rtl/lut_share_arbiter_if.sv
// lut_share_arbiter_if: lane request/response and shared LUT signals for the arbiter
interface lut_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 8
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BW_IN-1:0]  req_addr;
    logic [N_REQ-1:0]        req_ready;
    logic [BW_IN-1:0]        lut_addr;
    logic [BW_OUT-1:0]       lut_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [N_REQ*BW_OUT-1:0] rsp_data;
    logic [N_REQ-1:0]        rsp_ready;

    modport master (
        output req_valid, req_addr, lut_data, rsp_ready,
        input  req_ready, lut_addr, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_addr, lut_data, rsp_ready,
        output req_ready, lut_addr, rsp_valid, rsp_data
    );
endinterface

// File: rtl/lut_share_arbiter.sv
// lut_share_arbiter: round-robin sharing of one combinational LUT among N_REQ lanes
module lut_share_arbiter #(
    parameter int N_REQ  = 4,
    parameter int BW_IN  = 8,
    parameter int BW_OUT = 8
) (
    input logic              clk,
    input logic              rst_n,
    lut_share_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]        r_last;
    logic [N_REQ-1:0]        r_rsp_valid;
    logic [N_REQ*BW_OUT-1:0] r_rsp_data;
    logic [N_REQ-1:0]        w_elig;
    logic [N_REQ-1:0]        w_ready;
    logic [PTR_W-1:0]        w_grant;
    logic [PTR_W:0]          w_idx;
    logic                    w_found;
    logic [BW_IN-1:0]        w_lut_addr;

    // a full slot only blocks its lane if it is not draining this cycle
    assign w_elig = bus.req_valid & (~r_rsp_valid | bus.rsp_ready);

    // first eligible lane after the last winner, wrapping explicitly at N_REQ-1
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_idx   = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            w_idx = {1'b0, r_last} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(N_REQ)) w_idx = w_idx - (PTR_W+1)'(N_REQ);
            if (!w_found && w_elig[w_idx[PTR_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[PTR_W-1:0];
            end
        end
    end

    // one-hot grant and LUT address mux; both forced idle while in reset
    always_comb begin
        w_ready    = '0;
        w_lut_addr = '0;
        if (rst_n && w_found) w_ready[w_grant] = 1'b1;
        for (int i = 0; i < N_REQ; i++)
            if (w_ready[i]) w_lut_addr = bus.req_addr[i*BW_IN +: BW_IN];
    end

    // capture LUT result for the winner, drain consumed slots, advance the pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last      <= PTR_W'(N_REQ-1);
            r_rsp_valid <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_rsp_valid <= (r_rsp_valid & ~bus.rsp_ready) | w_ready;
            if (|w_ready) r_last <= w_grant;
            for (int i = 0; i < N_REQ; i++)
                if (w_ready[i]) r_rsp_data[i*BW_OUT +: BW_OUT] <= bus.lut_data;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.lut_addr  = w_lut_addr;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
endmodule
